// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 event receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int unsigned EV_W        = 10;
  localparam int unsigned EV_EXT      = 9;
  localparam int unsigned EV_MAKE     = 8;
  localparam int unsigned EV_CODE_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

endpackage

// File: rtl/ps2_event_rx_if.sv
// Key-event stream: show-ahead head entry, valid/ready handshake and fill level.
interface ps2_event_rx_if #(
  parameter int unsigned FIFO_DEPTH = 8
);

  logic [ps2_pkg::EV_W-1:0]    ev_data;
  logic                        ev_valid;
  logic                        ev_ready;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  modport master (
    output ev_data,
    output ev_valid,
    output fifo_count,
    input  ev_ready
  );

  modport slave (
    input  ev_data,
    input  ev_valid,
    input  fifo_count,
    output ev_ready
  );

endinterface

// File: rtl/ps2_event_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero when empty so the output reads 0 straight out of reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ps2_event_rx.sv
// PS/2 keyboard receiver: filtered line sampling, frame checking, E0/F0 prefix decoding
// and a buffered key-event stream.
module ps2_event_rx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk_100mhz,
  input  logic          rst,
  input  logic          ps2_c,
  input  logic          ps2_d,
  ps2_event_rx_if.master ev,
  output logic          frame_err,
  output logic          timeout,
  output logic          overflow
);

  localparam int unsigned TMO_LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TW        = $clog2(TMO_LIMIT + 1);
  localparam int unsigned FW        = $clog2(FILTER_LEN);

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [FW-1:0] fcnt [2];
  logic          c_prev;
  logic          fall_c;
  logic          d_bit;

  frame_state_t  state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic          byte_valid;
  logic          stop_err;
  logic [TW-1:0] tmo_cnt;

  logic          ext;
  logic          brk;
  logic          push;
  logic [EV_W-1:0] wdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      c_prev <= 1'b1;
      for (int unsigned i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= {ps2_d, ps2_c};
      sync2  <= sync1;
      c_prev <= filt[0];
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall_c = c_prev && !filt[0];
  assign d_bit  = filt[1];

  // A falling clock edge always wins over an expiring timeout: it reloads the counter.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      stop_err   <= 1'b0;
      timeout    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      stop_err   <= 1'b0;
      timeout    <= 1'b0;
      if (fall_c) begin
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!d_bit) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            shreg   <= {d_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par   <= d_bit;
            state <= ST_STOP;
          end
          default: begin
            if (d_bit && ((^shreg) ^ par)) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              stop_err  <= 1'b1;
            end
            state <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        if (tmo_cnt == TW'(TMO_LIMIT - 1)) begin
          state   <= ST_IDLE;
          timeout <= 1'b1;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  // shreg is stable while byte_valid is high: the FSM sits in IDLE until the next start bit.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      ext      <= 1'b0;
      brk      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && fifo_full && !pop;
      if (stop_err || timeout) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid) begin
        if (shreg == PS2_EXT) begin
          ext <= 1'b1;
        end else if (shreg == PS2_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
        end
      end
    end
  end

  assign push = byte_valid && (shreg != PS2_EXT) && (shreg != PS2_BRK);

  always_comb begin
    wdata                  = '0;
    wdata[EV_EXT]          = ext;
    wdata[EV_MAKE]         = !brk;
    wdata[EV_CODE_MSB:0]   = shreg;
  end

  assign pop         = ev.ev_valid && ev.ev_ready;
  assign ev.ev_valid = !fifo_empty;

  ps2_event_fifo #(
    .WIDTH(EV_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_100mhz),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (ev.ev_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (ev.fifo_count)
  );

endmodule

// File: tb/tb_ps2_event_rx.sv
// Bench for ps2_event_rx: directed scenarios plus randomized frames against a key-event model.
module tb_ps2_event_rx;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned FLEN  = 4;
  localparam int unsigned TMO   = 300;
  localparam int unsigned HALF  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_c = 1'b1;
  logic ps2_d = 1'b1;
  logic frame_err, timeout, overflow;

  ps2_event_rx_if #(.FIFO_DEPTH(DEPTH)) ev ();

  ps2_event_rx #(
    .CLK_HZ    (1000000),
    .FILTER_LEN(FLEN),
    .TIMEOUT_US(TMO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_100mhz(clk),
    .rst       (rst),
    .ps2_c     (ps2_c),
    .ps2_d     (ps2_d),
    .ev        (ev),
    .frame_err (frame_err),
    .timeout   (timeout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: key events are computed from the byte stream by the prefix rules.
  logic [9:0] exp_q[$];
  bit m_ext = 0, m_brk = 0, hold = 0;
  int exp_ferr = 0, exp_tmo = 0, exp_ovf = 0;

  function automatic void model_byte(input logic [7:0] b, input bit good);
    int unsigned code;
    if (!good) begin
      m_ext = 0; m_brk = 0; exp_ferr++;
      return;
    end
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      code = int'(b) + (m_ext ? 512 : 0) + (m_brk ? 0 : 256);
      m_ext = 0; m_brk = 0;
      if (hold && exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back(10'(code));
    end
  endfunction

  int n_ferr = 0, n_tmo = 0, n_ovf = 0, n_pop = 0, valid_cycles = 0;
  int unsigned first_valid_cyc = 0, tmo_cyc = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (frame_err) n_ferr++;
      if (timeout) begin n_tmo++; tmo_cyc = cyc; end
      if (overflow) n_ovf++;
      if (ev.ev_valid) begin
        valid_cycles++;
        if (!prev_valid) first_valid_cyc = cyc;
      end
      prev_valid = ev.ev_valid;
      if (ev.ev_valid && ev.ev_ready) begin
        n_pop++;
        if (exp_q.size() == 0) check("ev_unexpected_qsize", exp_q.size(), 1);
        else check("ev_data", ev.ev_data, exp_q.pop_front());
      end
    end
  end

  bit rnd_rdy = 0;
  int unsigned stop_fall_cyc = 0, last_fall_cyc = 0;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd_rdy) ev.ev_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_d = b;
    tick(HALF);
    ps2_c = 1'b0;
    last_fall_cyc = cyc;
    tick(HALF);
    ps2_c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    logic p;
    p = (($countones(b) % 2) == 0) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    ps2_d = !bad_stop;
    tick(HALF);
    ps2_c = 1'b0;
    stop_fall_cyc = cyc;
    model_byte(b, !bad_par && !bad_stop);
    tick(HALF);
    ps2_c = 1'b1;
    ps2_d = 1'b1;
    tick(2 * HALF);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] b;
    do b = 8'($urandom_range(1, 255)); while (b == 8'hE0 || b == 8'hF0);
    return b;
  endfunction

  initial begin
    int p0, f0, t0, o0;
    ev.ev_ready = 1'b0;
    tick(5);
    check("rst_ev_valid", ev.ev_valid, 0);
    check("rst_fifo_count", ev.fifo_count, 0);
    check("rst_ev_data", ev.ev_data, 0);
    rst = 1'b0;
    tick(5);
    check("idle_frame_err", frame_err, 0);

    // single make code: latency and one-cycle valid
    ev.ev_ready = 1'b1;
    valid_cycles = 0;
    p0 = n_pop;
    send_frame(8'h1C);
    tick(20);
    check("t1_latency", first_valid_cyc - stop_fall_cyc, 2 + FLEN + 2);
    check("t1_valid_cycles", valid_cycles, 1);
    check("t1_pops", n_pop - p0, 1);

    // prefix sequences
    p0 = n_pop;
    send_frame(8'hF0); send_frame(8'h1C);
    send_frame(8'hE0); send_frame(8'h75);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    tick(20);
    check("t2_pops", n_pop - p0, 3);
    check("t2_qsize", exp_q.size(), 0);

    // bad parity / bad stop
    f0 = n_ferr; p0 = n_pop;
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C);
    check("t3_par_ferr", n_ferr - f0, 1);
    send_frame(8'hF0);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C);
    tick(20);
    check("t3_stop_ferr", n_ferr - f0, 2);
    check("t3_pops", n_pop - p0, 2);

    // partial frame timeout also clears a pending E0
    send_frame(8'hE0);
    t0 = n_tmo;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_d = 1'b1;
    m_ext = 0; m_brk = 0; exp_tmo++;
    for (int i = 0; i < int'(TMO) + 50 && n_tmo == t0; i++) tick(1);
    check("t4_timeout_pulses", n_tmo - t0, 1);
    check("t4_timeout_window", ((tmo_cyc - last_fall_cyc) >= TMO) && ((tmo_cyc - last_fall_cyc) <= TMO + 10), 1);
    p0 = n_pop;
    send_frame(8'h32);
    tick(20);
    check("t4_pops", n_pop - p0, 1);

    // overflow with consumer stalled
    ev.ev_ready = 1'b0;
    hold = 1; o0 = n_ovf;
    send_frame(8'h15); send_frame(8'h1D); send_frame(8'h24);
    send_frame(8'h2D); send_frame(8'h2C);
    tick(10);
    check("t5_fifo_count", ev.fifo_count, DEPTH);
    check("t5_overflow", n_ovf - o0, 1);
    check("t5_head", ev.ev_data, exp_q[0]);
    tick(7);
    check("t5_head_hold", ev.ev_data, exp_q[0]);
    hold = 0;
    ev.ev_ready = 1'b1;
    tick(10);
    check("t5_drained_q", exp_q.size(), 0);
    check("t5_drained_cnt", ev.fifo_count, 0);

    // reset mid-frame with events queued
    ev.ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(rand_code());
    send_frame(8'hE0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("t6_pre_count", ev.fifo_count, 3);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", ev.ev_valid, 0);
    check("t6_rst_count", ev.fifo_count, 0);
    check("t6_rst_data", ev.ev_data, 0);
    exp_q.delete(); m_ext = 0; m_brk = 0;
    tick(3);
    rst = 1'b0;
    ps2_d = 1'b1;
    tick(5);
    ev.ev_ready = 1'b1;
    p0 = n_pop;
    send_frame(8'h1C);
    tick(20);
    check("t6_pops", n_pop - p0, 1);

    // 2-cycle clock glitch must be filtered out
    f0 = n_ferr; p0 = n_pop;
    ps2_d = 1'b1;
    ps2_c = 1'b0;
    tick(2);
    ps2_c = 1'b1;
    tick(20);
    check("t7_glitch_ferr", n_ferr - f0, 0);
    send_frame(8'h4B);
    tick(20);
    check("t7_pops", n_pop - p0, 1);
    check("t7_ferr_after", n_ferr - f0, 0);

    // randomized traffic with a jittery consumer
    rnd_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0: send_frame(8'hE0);
        1: send_frame(8'hF0);
        2: send_frame(rand_code(), 1'b1, 1'b0);
        3: send_frame(rand_code(), 1'b0, 1'b1);
        default: send_frame(8'($urandom_range(0, 255)));
      endcase
    end
    rnd_rdy = 0;
    ev.ev_ready = 1'b1;
    tick(30);
    check("t8_qsize", exp_q.size(), 0);
    check("total_frame_err", n_ferr, exp_ferr);
    check("total_timeout", n_tmo, exp_tmo);
    check("total_overflow", n_ovf, exp_ovf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_event_rx.md
Name: ps2_event_rx

Overview:
Next-generation PS/2 keyboard receiver. Fully synchronous to clk_100mhz; no logic is clocked by ps2_c.
- Filters the PS/2 lines and validates every 11-bit frame: start bit, odd parity, stop bit, inter-bit timeout.
- Decodes E0 (extended) and F0 (break) prefixes into 10-bit key events.
- Buffers events in a parametrised FIFO with a valid/ready handshake.
- Sits between the PS/2 pins and the piano note-control logic, replacing the single-register key_event output.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz.
FILTER_LEN, 4, consecutive identical synchronised samples required to change a filtered level (range 2..16).
TIMEOUT_US, 2000, maximum time between falling edges inside a frame before it is aborted.
FIFO_DEPTH, 8, event FIFO entries; must be a power of two, at least 2.

Ports:
clk_100mhz  input  1  system clock.
rst  input  1  asynchronous active-high reset.
ps2_c  input  1  raw PS/2 clock, asynchronous.
ps2_d  input  1  raw PS/2 data, asynchronous.
ev_data  output  10  head event: [9]=extended, [8]=make (1 = press, 0 = release), [7:0]=scan code.
ev_valid  output  1  FIFO not empty.
ev_ready  input  1  consumer accepts ev_data when ev_valid && ev_ready.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current number of stored events.
frame_err  output  1  one-cycle pulse on a bad start, parity or stop bit.
timeout  output  1  one-cycle pulse when a partial frame is aborted.
overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full.

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. Asserting rst clears everything immediately, including mid-frame and with a non-empty FIFO.
  - ev_data=0, ev_valid=0, fifo_count=0, all pulses 0.
  - Filtered lines set to 1, FSM to IDLE, prefix flags cleared.
- Input conditioning:
  - Two-flop synchroniser on each line.
  - Each filtered level changes only after FILTER_LEN consecutive equal synchronised samples.
  - fall_c is a one-cycle pulse on a 1->0 transition of filtered clock. All bit sampling uses filtered data at fall_c.
- Frame FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on fall_c with data=0, go to DATA and clear bit counter. With data=1, assert frame_err and stay in IDLE.
  - DATA: shift bits in LSB first; after 8 bits go to PARITY.
  - PARITY: store the parity bit, go to STOP.
  - STOP: byte is good if stop=1 and the XOR of the 8 data bits plus parity is 1 (odd parity). A good byte raises byte_valid for one cycle on the next clock. Otherwise pulse frame_err, discard the byte and clear both prefix flags. Return to IDLE in either case.
- Timeout:
  - A counter runs in any non-IDLE state and reloads on every fall_c.
  - When it reaches CLK_HZ/1000000*TIMEOUT_US cycles: go to IDLE, pulse timeout, clear prefix flags.
- Decoder, acting on byte_valid:
  - 0xE0 sets ext.
  - 0xF0 sets brk.
  - Any other byte pushes {ext, ~brk, byte} and clears both flags. 0xE1 is treated as an ordinary code.
  - Repeated prefixes are idempotent.
- FIFO:
  - Show-ahead: ev_data is the head entry whenever ev_valid=1; ev_data holds its value while ev_valid && !ev_ready.
  - Pop occurs when ev_valid && ev_ready.
  - Push while full is dropped and pulses overflow, unless a pop happens in the same cycle; then both complete, fifo_count stays equal, and there is no overflow.
  - Push and pop together in a non-full, non-empty FIFO leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: fall_c of the stop bit in cycle N gives byte_valid in N+1, FIFO write in N+2, and ev_valid=1 in N+2 if the FIFO was empty.
- Simultaneous events: a timeout and a fall_c in the same cycle are resolved in favour of fall_c (counter reloads, no timeout).

Decomposition:
- Shared package ps2_pkg holds:
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0.
  - Event field positions EV_EXT=9, EV_MAKE=8, EV_CODE_MSB=7.
  - EV_W=10.
  - FSM state encodings.
- One sub-module, ps2_event_fifo, with parameters WIDTH and DEPTH: synchronous FIFO with push/pop, full/empty, count and show-ahead output.
- Filter, FSM, timeout and decoder stay in ps2_event_rx.

Test Plan:
- Frame 0x1C with odd parity, ev_ready=1 -> one event ev_data=10'h11C; ev_valid high for exactly one cycle, 2 cycles after the stop-bit fall_c.
- Sequences F0 1C, then E0 75, then E0 F0 75 -> events 10'h01C, 10'h375, 10'h275 in order; no prefix events emitted.
- Frame 0x1C with wrong parity, then a valid 0x1C -> frame_err pulses once; only 10'h11C is queued. Repeat with stop=0 -> same result.
- Five data bits then bus idle -> timeout pulse after 200000 cycles (defaults), FSM back in IDLE; a following valid 0x32 gives 10'h132.
- FIFO_DEPTH=4, ev_ready=0, 5 make codes 0x15, 0x1D, 0x24, 0x2D, 0x2C -> fifo_count=4 and overflow pulses on the 5th. Then ev_ready=1 -> 10'h115, 10'h11D, 10'h124, 10'h12D.
- Assert rst mid-frame with 3 events queued -> all outputs 0 immediately; the next complete frame decodes correctly.
- A 2-cycle glitch on ps2_c with FILTER_LEN=4 -> no bit sampled, no error.
